// File: rtl/pipe_stage_skid_if.sv
// rtl/pipe_stage_skid_if.sv - handshake bundle between upstream, skid stage and downstream
interface pipe_stage_skid_if #(
  parameter int DATA_W = 143,
  parameter int CTRL_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;

  modport master (
    output in_valid, in_data, in_ctrl, out_ready,
    input  in_ready, out_valid, out_data, out_ctrl
  );

  modport slave (
    input  in_valid, in_data, in_ctrl, out_ready,
    output in_ready, out_valid, out_data, out_ctrl
  );
endinterface

// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - two-entry registered pipeline stage with skid buffer, flush and stall counter
module pipe_stage_skid #(
  parameter int DATA_W = 143,
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  pipe_stage_skid_if.slave bus,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [DATA_W-1:0] main_data, skid_data;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic              main_valid, skid_valid;
  logic              accept, issue;
  logic              ld_main_in, ld_main_skid, ld_skid;

  assign main_valid = (state_q != EMPTY);
  assign skid_valid = (state_q == FULL);

  // Ready comes only from registered state so upstream never sees a comb loop.
  assign bus.in_ready  = !skid_valid & !rst;
  assign bus.out_valid = main_valid;
  assign bus.out_data  = main_data;
  assign bus.out_ctrl  = main_ctrl;

  assign accept = bus.in_valid & bus.in_ready;
  assign issue  = main_valid & bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            ld_main_in = 1'b1;
            state_d    = ONE;
          end
        end
        ONE: begin
          if (accept && issue) begin
            ld_main_in = 1'b1;
          end else if (accept) begin
            ld_skid = 1'b1;
            state_d = FULL;
          end else if (issue) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (issue) begin
            ld_main_skid = 1'b1;
            state_d      = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Flush kills control payloads but leaves datapath registers untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_data <= '0;
      main_ctrl <= '0;
      skid_data <= '0;
      skid_ctrl <= '0;
    end else if (flush) begin
      main_ctrl <= '0;
      skid_ctrl <= '0;
    end else begin
      if (ld_main_in) begin
        main_data <= bus.in_data;
        main_ctrl <= bus.in_ctrl;
      end else if (ld_main_skid) begin
        main_data <= skid_data;
        main_ctrl <= skid_ctrl;
      end
      if (ld_skid) begin
        skid_data <= bus.in_data;
        skid_ctrl <= bus.in_ctrl;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (main_valid && !bus.out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb/tb_pipe_stage_skid.sv - directed and random checks of pipe_stage_skid
module tb_pipe_stage_skid;

  localparam int DW = 143;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  logic flush2;
  logic [15:0] stall_cnt;
  logic [3:0]  stall_cnt2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_stage_skid_if #(.DATA_W(DW), .CTRL_W(CW)) bus ();
  pipe_stage_skid_if #(.DATA_W(8), .CTRL_W(4)) bus2 ();

  pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .bus       (bus.slave),
    .stall_cnt (stall_cnt)
  );

  pipe_stage_skid #(.DATA_W(8), .CTRL_W(4), .CNT_W(4)) dut_sat (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush2),
    .bus       (bus2.slave),
    .stall_cnt (stall_cnt2)
  );

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [DW+CW-1:0] q[$];
  logic [DW-1:0]    rd;
  logic             acc, iss;

  initial begin
    rst = 1'b1; flush = 1'b0; flush2 = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_ctrl = '0; bus.out_ready = 1'b0;
    bus2.in_valid = 1'b0; bus2.in_data = '0; bus2.in_ctrl = '0; bus2.out_ready = 1'b0;
    #1;
    chk("rst_in_ready", bus.in_ready, 0);
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_ctrl", bus.out_ctrl, 0);
    chk("rst_stall", stall_cnt, 0);
    chk("rst_in_ready_after", bus.in_ready, 1);

    // streaming
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      bus.in_data = DW'(i);
      bus.in_ctrl = CW'(i);
      tick();
      chk("stream_valid", bus.out_valid, 1);
      chk("stream_data", bus.out_data, i);
      chk("stream_ready", bus.in_ready, 1);
    end
    bus.in_valid = 1'b0;
    tick();
    chk("stream_drained", bus.out_valid, 0);
    chk("stream_stall", stall_cnt, 0);

    // back-pressure
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = DW'('hA1); bus.in_ctrl = 8'h01;
    tick();
    chk("bp_a_main", bus.out_data, 'hA1);
    chk("bp_ready_one", bus.in_ready, 1);
    bus.in_data = DW'('hB2); bus.in_ctrl = 8'h02;
    tick();
    chk("bp_ready_full", bus.in_ready, 0);
    chk("bp_a_stable", bus.out_data, 'hA1);
    bus.in_data = DW'('hC3); bus.in_ctrl = 8'h03;
    tick(); tick();
    chk("bp_a_stable2", bus.out_data, 'hA1);
    chk("bp_ctrl_stable", bus.out_ctrl, 8'h01);
    chk("bp_stall3", stall_cnt, 3);
    bus.out_ready = 1'b1;
    tick();
    chk("bp_b_out", bus.out_data, 'hB2);
    chk("bp_ready_back", bus.in_ready, 1);
    tick();
    chk("bp_c_out", bus.out_data, 'hC3);
    chk("bp_c_ctrl", bus.out_ctrl, 8'h03);
    bus.in_valid = 1'b0;
    tick();
    chk("bp_empty", bus.out_valid, 0);
    chk("bp_stall_final", stall_cnt, 3);

    // flush while full, D offered in the flush cycle
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = DW'('hE5); bus.in_ctrl = 8'h05;
    tick();
    bus.in_data = DW'('hF6); bus.in_ctrl = 8'h06;
    tick();
    chk("fl_full", bus.in_ready, 0);
    bus.in_data = DW'('hD4); bus.in_ctrl = 8'h07;
    flush = 1'b1;
    tick();
    chk("fl_valid", bus.out_valid, 0);
    chk("fl_ctrl", bus.out_ctrl, 0);
    chk("fl_ready", bus.in_ready, 1);
    chk("fl_stall", stall_cnt, 5);
    flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    tick();
    chk("fl_no_d", bus.out_valid, 0);
    chk("fl_data_kept", bus.out_data, 'hE5);

    // reset while full
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = DW'('h17); bus.in_ctrl = 8'h11;
    tick();
    bus.in_data = DW'('h28); bus.in_ctrl = 8'h22;
    tick();
    chk("rf_full", bus.in_ready, 0);
    rst = 1'b1;
    #1;
    chk("rf_ready_in_rst", bus.in_ready, 0);
    tick();
    chk("rf_ready_in_rst2", bus.in_ready, 0);
    rst = 1'b0; bus.in_valid = 1'b0;
    #1;
    chk("rf_valid", bus.out_valid, 0);
    chk("rf_data", bus.out_data, 0);
    chk("rf_ctrl", bus.out_ctrl, 0);
    chk("rf_stall", stall_cnt, 0);
    chk("rf_ready_after", bus.in_ready, 1);

    // stall counter saturation at CNT_W=4
    bus2.in_valid = 1'b1; bus2.in_data = 8'h5A; bus2.in_ctrl = 4'h3;
    tick();
    bus2.in_valid = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("sat_mid", stall_cnt2, 10);
    for (int i = 0; i < 10; i++) tick();
    chk("sat_cap", stall_cnt2, 15);
    chk("sat_valid", bus2.out_valid, 1);
    chk("sat_data", bus2.out_data, 8'h5A);

    // random valid/ready against a reference queue
    for (int c = 0; c < 10000; c++) begin
      rd = DW'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_data   = rd;
      bus.in_ctrl   = CW'($urandom());
      bus.out_ready = ($urandom_range(0, 2) != 0);
      chk("rnd_in_ready", bus.in_ready, (q.size() < 2));
      chk("rnd_out_valid", bus.out_valid, (q.size() > 0));
      if (q.size() > 0) begin
        chk("rnd_out_data", bus.out_data, q[0][DW-1:0]);
        chk("rnd_out_ctrl", bus.out_ctrl, q[0][DW+CW-1:DW]);
      end
      acc = bus.in_valid && (q.size() < 2);
      iss = (q.size() > 0) && bus.out_ready;
      tick();
      if (iss) void'(q.pop_front());
      if (acc) q.push_back({bus.in_ctrl, bus.in_data});
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    tick(); tick();
    chk("rnd_drained", bus.out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
